// File: rtl/alu_pkg.sv
// Shared constants and types for the ALU command sequencer: opcodes, bus layout,
// FSM states and the queued command format.
package alu_pkg;

  localparam int DATA_W    = 4;
  localparam int OP_W      = 4;
  localparam int SW_W      = 16;
  localparam int LED_W     = 5;
  localparam int SW_A_LSB  = 0;
  localparam int SW_B_LSB  = 4;
  localparam int SW_OP_LSB = 8;
  localparam int LED_CARRY = 4;

  localparam logic [OP_W-1:0] OP_ADD  = 4'd0;
  localparam logic [OP_W-1:0] OP_SUB  = 4'd1;
  localparam logic [OP_W-1:0] OP_MUL  = 4'd2;
  localparam logic [OP_W-1:0] OP_DIV  = 4'd3;
  localparam logic [OP_W-1:0] OP_AND  = 4'd4;
  localparam logic [OP_W-1:0] OP_OR   = 4'd5;
  localparam logic [OP_W-1:0] OP_XOR  = 4'd6;
  localparam logic [OP_W-1:0] OP_NAND = 4'd7;
  localparam logic [OP_W-1:0] OP_NOR  = 4'd8;
  localparam logic [OP_W-1:0] OP_XNOR = 4'd9;
  localparam logic [OP_W-1:0] OP_SHL  = 4'd10;
  localparam logic [OP_W-1:0] OP_SHR  = 4'd11;
  localparam logic [OP_W-1:0] OP_GT   = 4'd12;
  localparam logic [OP_W-1:0] OP_LT   = 4'd13;
  localparam logic [OP_W-1:0] OP_EQ   = 4'd14;
  localparam logic [OP_W-1:0] OP_INC  = 4'd15;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DRIVE  = 2'd1,
    S_SAMPLE = 2'd2,
    S_HOLD   = 2'd3
  } state_e;

  // Queued command; chain sits in the MSB so the flat FIFO word is {chain, op, b, a}.
  typedef struct packed {
    logic              chain;
    logic [OP_W-1:0]   op;
    logic [DATA_W-1:0] b;
    logic [DATA_W-1:0] a;
  } cmd_t;

  localparam int CMD_W = $bits(cmd_t);

endpackage

// File: rtl/alu_cmd_fifo.sv
// Synchronous command FIFO; full/empty come from a registered occupancy count,
// pointers wrap naturally because DEPTH is a power of two.
module alu_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 13
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             wdata,
  output logic [W-1:0]             rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_push, do_pop;

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rdata   = mem_q[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    if (do_push) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (do_pop) rd_ptr_d = rd_ptr_q + AW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: the count decides what is valid.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// Feeds the external gate-level ALU from a queued command stream: drive the bus,
// let it settle, sample, and hand the result out over a valid/ready port.
module alu_op_sequencer
  import alu_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int SETTLE_CYC = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [OP_W-1:0]   cmd_op,
  input  logic [DATA_W-1:0] cmd_a,
  input  logic [DATA_W-1:0] cmd_b,
  input  logic              cmd_chain,
  output logic [SW_W-1:0]   alu_sw,
  input  logic [LED_W-1:0]  alu_led,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [DATA_W-1:0] res_data,
  output logic              res_carry,
  output logic [OP_W-1:0]   res_op,
  output logic              res_dz,
  output logic              busy
);

  localparam int CW = $clog2(SETTLE_CYC + 1);

  state_e                     state_q, state_d;
  logic [CW-1:0]              cnt_q, cnt_d;
  logic [DATA_W-1:0]          acc_q, acc_d;
  logic [SW_W-1:0]            sw_q, sw_d;
  logic [DATA_W-1:0]          res_data_q, res_data_d;
  logic                       res_carry_q, res_carry_d;
  logic [OP_W-1:0]            res_op_q, res_op_d;
  logic                       res_dz_q, res_dz_d;

  logic [CMD_W-1:0]           wr_bits, rd_bits;
  cmd_t                       rd_cmd;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;
  logic                       fifo_full, fifo_empty, fifo_pop, fifo_push;
  logic [DATA_W-1:0]          eff_a;
  logic                       div_zero;

  assign wr_bits   = {cmd_chain, cmd_op, cmd_b, cmd_a};
  assign rd_cmd    = cmd_t'(rd_bits);
  assign fifo_push = cmd_valid && !fifo_full;

  alu_cmd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (CMD_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdata (wr_bits),
    .rdata (rd_bits),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Divide-by-zero is judged from the bus actually driven, so chained A is irrelevant.
  assign div_zero = (sw_q[SW_OP_LSB +: OP_W] == OP_DIV) && (sw_q[SW_B_LSB +: DATA_W] == '0);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    sw_d        = sw_q;
    res_data_d  = res_data_q;
    res_carry_d = res_carry_q;
    res_op_d    = res_op_q;
    res_dz_d    = res_dz_q;
    fifo_pop    = 1'b0;
    eff_a       = '0;
    case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop                      = 1'b1;
          eff_a                         = rd_cmd.chain ? acc_q : rd_cmd.a;
          sw_d                          = '0;
          sw_d[SW_A_LSB  +: DATA_W]     = eff_a;
          sw_d[SW_B_LSB  +: DATA_W]     = rd_cmd.b;
          sw_d[SW_OP_LSB +: OP_W]       = rd_cmd.op;
          cnt_d                         = CW'(SETTLE_CYC);
          state_d                       = S_DRIVE;
        end
      end
      S_DRIVE: begin
        if (cnt_q <= CW'(1)) state_d = S_SAMPLE;
        else                 cnt_d   = cnt_q - CW'(1);
      end
      S_SAMPLE: begin
        res_op_d = sw_q[SW_OP_LSB +: OP_W];
        if (div_zero) begin
          res_data_d  = '0;
          res_carry_d = 1'b0;
          res_dz_d    = 1'b1;
        end else begin
          res_data_d  = alu_led[DATA_W-1:0];
          res_carry_d = alu_led[LED_CARRY];
          res_dz_d    = 1'b0;
        end
        acc_d   = res_data_d;
        state_d = S_HOLD;
      end
      S_HOLD: begin
        if (res_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      acc_q       <= '0;
      sw_q        <= '0;
      res_data_q  <= '0;
      res_carry_q <= 1'b0;
      res_op_q    <= '0;
      res_dz_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      sw_q        <= sw_d;
      res_data_q  <= res_data_d;
      res_carry_q <= res_carry_d;
      res_op_q    <= res_op_d;
      res_dz_q    <= res_dz_d;
    end
  end

  assign cmd_ready = !fifo_full;
  assign alu_sw    = sw_q;
  assign res_valid = (state_q == S_HOLD);
  assign res_data  = res_data_q;
  assign res_carry = res_carry_q;
  assign res_op    = res_op_q;
  assign res_dz    = res_dz_q;
  assign busy      = (state_q != S_IDLE) || (fifo_count != '0);

endmodule
